relu_layer_sequencer: RTL
=========================

Name: relu_layer_sequencer

Overview:
- Sequences one autoencoder layer's activation pass.
- Reads LEN signed pre-activation words from the layer accumulator buffer (1-cycle synchronous read).
- Passes each word through the existing ReLu datapath.
- Streams the results to the next layer with a valid/ready handshake, then pulses done.
- Sits between the MAC/accumulate stage and the next layer's input buffer or the decoder.

Parameters:
- NBITS, 16: data width; signed two's-complement fixed-point (Q8.8 in current build).
- ADDR_W, 6: buffer address width; max layer length 2^ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a pass; sampled only in IDLE.
- len  in  ADDR_W+1  element count, 0..2^ADDR_W; latched on start acceptance.
- busy  out  1  high from start acceptance until the DONE cycle inclusive.
- done  out  1  one-cycle pulse at end of pass.
- rd_en  out  1  buffer read strobe.
- rd_addr  out  ADDR_W  buffer read address.
- rd_data  in  NBITS  buffer data, valid the cycle after rd_en.
- out_valid  out  1  out_data/out_idx valid.
- out_ready  in  1  downstream accepts.
- out_data  out  NBITS  ReLU result.
- out_idx  out  ADDR_W  element index of out_data.

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, rd_en, out_valid = 0; rd_addr, out_data, out_idx, element counter, latched len = 0.
- FSM states: IDLE, RD, CAP, OUT, DONE.
- IDLE: on start=1:
  - latch len, clear counter i, busy=1.
  - len=0 -> DONE (no reads, no outputs); else -> RD.
- RD: rd_en=1, rd_addr=i for exactly one cycle -> CAP.
- CAP: register ReLu(rd_data) into out_data, i into out_idx -> OUT.
- OUT: out_valid=1; out_data/out_idx held stable while out_ready=0, stall is unbounded.
  - On out_valid&&out_ready: i=i+1; if i==len-1 -> DONE, else -> RD. out_valid drops the following cycle.
- DONE: done=1, busy=1 for one cycle -> IDLE; busy=0 in IDLE.
- Latency:
  - start accepted at edge k: rd_en high in cycle k+1, out_valid high from cycle k+3.
  - Minimum 3 cycles per element with out_ready tied high.
- ReLU rule: MSB=1 -> 0; else pass unchanged. 0x8000 -> 0x0000, 0x0000 -> 0x0000, 0x7FFF -> 0x7FFF.
- start while busy: ignored, no queueing.
- len=2^ADDR_W: all addresses 0..2^ADDR_W-1 read; no wrap, no re-read of address 0.
- rd_en is never asserted outside RD; rd_data is ignored outside CAP.
- Reset mid-pass: aborts immediately; no done pulse; next start begins at address 0.

Optional Feature:
- Macro ACT_ZERO_CNT_EN.
- Defined:
  - Adds output zero_cnt [ADDR_W:0], the number of elements the current pass clamped to zero (MSB=1 inputs only; a true 0x0000 input is not counted).
  - Cleared on start acceptance and by reset; increments at the CAP edge; holds its value after DONE until the next start.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package ae_pkg:
  - NBITS/ADDR_W defaults.
  - FSM state encoding constants (IDLE=0, RD=1, CAP=2, OUT=3, DONE=4, 3-bit).
  - Fixed-point format constants (FRAC_BITS=8).
- Sub-module: the existing ReLu (NBITS) instance, combinational, fed by rd_data. No new sub-module.

Test Plan:
- len=2, buffer[0]=0xF900, buffer[1]=0x0300, out_ready=1 -> outputs (idx0, 0x0000), (idx1, 0x0300).
  - done pulses once, 7 cycles after start acceptance; zero_cnt=1 if enabled.
- len=0 -> no rd_en, no out_valid; done pulses the cycle after start acceptance; busy high 2 cycles.
- len=4, out_ready low 5 cycles on element 2 -> out_data/out_idx stable throughout; no extra rd_en; each element emitted exactly once.
- Boundary data 0x8000, 0x7FFF, 0x0000, 0xFFFF -> 0x0000, 0x7FFF, 0x0000, 0x0000; zero_cnt=2.
- start asserted again mid-pass (len=3) -> ignored; exactly 3 outputs.
- rst pulse during OUT of element 1 (len=4) -> all outputs 0 asynchronously, no done pulse; a new start with len=2 reads addresses 0, 1.

Source files
------------

// File: rtl/ae_pkg.sv
// Shared autoencoder definitions: default widths, sequencer state encoding, fixed-point format.
package ae_pkg;

    localparam int NBITS_DEF  = 16;
    localparam int ADDR_W_DEF = 6;
    localparam int FRAC_BITS  = 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_OUT  = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/relu_layer_sequencer_relu.sv
// ReLU datapath: negative inputs (MSB set) clamp to zero, everything else passes unchanged.
// Purely combinational, no state, no backpressure.
module relu_layer_sequencer_relu #(
    parameter int NBITS = 16
) (
    input  logic [NBITS-1:0] i_din,
    output logic [NBITS-1:0] o_dout
);

    assign o_dout = i_din[NBITS-1] ? '0 : i_din;

endmodule

// File: rtl/relu_layer_sequencer.sv
// Activation pass: reads i_len buffer words, ReLUs them, streams out (idx, data), then pulses done.
// 3 cycles/element minimum; OUT holds indefinitely while i_out_ready is low. ACT_ZERO_CNT_EN adds o_zero_cnt.
module relu_layer_sequencer
    import ae_pkg::*;
#(
    parameter int NBITS  = NBITS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W:0]   i_len,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [NBITS-1:0]  i_rd_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [NBITS-1:0]  o_out_data,
`ifdef ACT_ZERO_CNT_EN
    output logic [ADDR_W:0]   o_zero_cnt,
`endif
    output logic [ADDR_W-1:0] o_out_idx
);

    localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W-1:0] r_i;
    logic [NBITS-1:0]  r_out_data;
    logic [ADDR_W-1:0] r_out_idx;
    logic [NBITS-1:0]  w_relu;
    logic              w_accept;
    logic              w_fire;
    logic              w_last;

    relu_layer_sequencer_relu #(.NBITS(NBITS)) u_relu (
        .i_din  (i_rd_data),
        .o_dout (w_relu)
    );

    assign w_accept = (r_state == S_IDLE) && i_start;
    assign w_fire   = (r_state == S_OUT) && i_out_ready;
    // Compare against the pre-increment index so len = 2^ADDR_W ends after address 2^ADDR_W-1.
    assign w_last   = ({1'b0, r_i} == (r_len - LEN_ONE));

    assign o_rd_addr  = r_i;
    assign o_out_data = r_out_data;
    assign o_out_idx  = r_out_idx;

    always_comb begin
        w_next      = r_state;
        o_busy      = 1'b1;
        o_done      = 1'b0;
        o_rd_en     = 1'b0;
        o_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = i_start;
                if (i_start) begin
                    w_next = (i_len == '0) ? S_DONE : S_RD;
                end
            end
            S_RD: begin
                o_rd_en = 1'b1;
                w_next  = S_CAP;
            end
            S_CAP: w_next = S_OUT;
            S_OUT: begin
                o_out_valid = 1'b1;
                if (i_out_ready) begin
                    w_next = w_last ? S_DONE : S_RD;
                end
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                o_busy = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_i        <= '0;
            r_out_data <= '0;
            r_out_idx  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_len <= i_len;
                r_i   <= '0;
            end else if (w_fire) begin
                r_i <= r_i + IDX_ONE;
            end
            if (r_state == S_CAP) begin
                r_out_data <= w_relu;
                r_out_idx  <= r_i;
            end
        end
    end

`ifdef ACT_ZERO_CNT_EN
    logic [ADDR_W:0] r_zero_cnt;

    // Only genuinely negative inputs count; a true zero input passes through unclamped.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_zero_cnt <= '0;
        end else if (w_accept) begin
            r_zero_cnt <= '0;
        end else if ((r_state == S_CAP) && i_rd_data[NBITS-1]) begin
            r_zero_cnt <= r_zero_cnt + LEN_ONE;
        end
    end

    assign o_zero_cnt = r_zero_cnt;
`endif

endmodule
